// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_half_subtractor.sv
// Half-subtractor cell: difference and borrow of x - y.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic b
);

  assign d = x ^ y;
  assign b = ~x & y;

endmodule : half_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, with start/busy/done handshake.
// D/Bo are only loaded on the completion edge, so they never show a partial result.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bo
);

  // One extra counter bit keeps WIDTH=1 legal.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] res_reg, res_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic             borrow_reg, borrow_next;
  logic             bo_reg, bo_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic             hs1_d, hs1_b, hs2_b;
  logic             bit_d, bit_bout;
  logic [WIDTH-1:0] res_shift;

  // Full subtract of the current bit: two half-subtractors, borrows ORed here.
  half_subtractor u_hs_xy (
    .x (a_reg[0]),
    .y (b_reg[0]),
    .d (hs1_d),
    .b (hs1_b)
  );

  half_subtractor u_hs_r (
    .x (hs1_d),
    .y (borrow_reg),
    .d (bit_d),
    .b (hs2_b)
  );

  assign bit_bout = hs1_b | hs2_b;

  // Result register shifts right with the new difference bit entering at the MSB.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_res
      if (gi == WIDTH - 1) begin : g_msb
        assign res_shift[gi] = bit_d;
      end else begin : g_low
        assign res_shift[gi] = res_reg[gi+1];
      end
    end
  endgenerate

  // Next-state and datapath update; everything holds unless the state says otherwise.
  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    res_next    = res_reg;
    d_next      = d_reg;
    borrow_next = borrow_reg;
    bo_next     = bo_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          a_next      = A;
          b_next      = B;
          res_next    = '0;
          borrow_next = 1'b0;
          cnt_next    = '0;
          state_next  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_next      = a_reg >> 1;
        b_next      = b_reg >> 1;
        res_next    = res_shift;
        borrow_next = bit_bout;
        cnt_next    = cnt_reg + CW'(1);
        if (cnt_reg == LAST_BIT) begin
          d_next     = res_shift;
          bo_next    = bit_bout;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      d_reg      <= '0;
      borrow_reg <= 1'b0;
      bo_reg     <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      res_reg    <= res_next;
      d_reg      <= d_next;
      borrow_reg <= borrow_next;
      bo_reg     <= bo_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign busy = (state_reg == ST_SHIFT);
  assign done = (state_reg == ST_DONE);
  assign D    = d_reg;
  assign Bo   = bo_reg;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance signals
  logic       rst8, start8, busy8, done8, bo8;
  logic [7:0] a8, b8, d8;
  // WIDTH=1 instance signals
  logic       rst1, start1, busy1, done1, bo1;
  logic [0:0] a1, b1, d1;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .D(d8), .Bo(bo8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .D(d1), .Bo(bo1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Last completed result expected on the WIDTH=8 outputs (for hold checks).
  logic [7:0] prev_d;
  logic       prev_bo;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_d;
    logic       exp_bo;
  } vec8_t;

  typedef struct {
    logic [0:0] a;
    logic [0:0] b;
    logic [0:0] exp_d;
    logic       exp_bo;
  } vec1_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One WIDTH=8 operation. Caller must be at a negedge with the DUT idle; start
  // is driven immediately, so consecutive calls exercise the earliest restart.
  // inj_busy: busy-cycle index (1-based) at which a stray start is driven (0 = none).
  // inj_done: also drive a stray start during the done cycle.
  task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] exp_d, input logic exp_bo,
                     input int inj_busy, input bit inj_done);
    int busy_cnt = 0;
    int cycles   = 0;
    int done_cnt = 0;
    bit hold_ok  = 1'b1;
    start8 = 1'b1;
    a8     = a;
    b8     = b;
    @(negedge clk);
    while (!done8 && cycles < 40) begin
      start8 = 1'b0;
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      if (busy8) begin
        busy_cnt++;
        if (busy_cnt == inj_busy) begin
          start8 = 1'b1;
          a8     = 8'hAA;
          b8     = 8'h55;
        end
        if (d8 !== prev_d || bo8 !== prev_bo) hold_ok = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    check({name, "_timeout"}, 32'(done8), 32'd1);
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
    check({name, "_hold_during_busy"}, 32'(hold_ok), 32'd1);
    check({name, "_busy_in_done"}, 32'(busy8), 32'd0);
    check({name, "_D"}, 32'(d8), 32'(exp_d));
    check({name, "_Bo"}, 32'(bo8), 32'(exp_bo));
    start8 = inj_done;
    a8     = 8'hAA;
    b8     = 8'h55;
    @(negedge clk);
    start8 = 1'b0;
    check({name, "_done_single"}, 32'(done8), 32'd0);
    check({name, "_idle_after"}, 32'(busy8), 32'd0);
    check({name, "_D_hold"}, 32'(d8), 32'(exp_d));
    check({name, "_Bo_hold"}, 32'(bo8), 32'(exp_bo));
    // Extra idle cycle to confirm a stray start in DONE did not launch anything.
    if (inj_done) begin
      @(negedge clk);
      check({name, "_done_start_ignored"}, 32'(busy8), 32'd0);
    end
    prev_d  = exp_d;
    prev_bo = exp_bo;
    done_cnt = 0;
  endtask

  task automatic op1(input string name, input logic [0:0] a, input logic [0:0] b,
                     input logic [0:0] exp_d, input logic exp_bo);
    int busy_cnt = 0;
    int cycles   = 0;
    start1 = 1'b1;
    a1     = a;
    b1     = b;
    @(negedge clk);
    while (!done1 && cycles < 10) begin
      start1 = 1'b0;
      if (busy1) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
    start1 = 1'b0;
    check({name, "_timeout"}, 32'(done1), 32'd1);
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd1);
    check({name, "_D"}, 32'(d1), 32'(exp_d));
    check({name, "_Bo"}, 32'(bo1), 32'(exp_bo));
    @(negedge clk);
  endtask

  vec8_t tbl8 [6];
  vec1_t tbl1 [4];

  initial begin
    tbl8[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    tbl8[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    tbl8[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    tbl8[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    tbl8[4] = '{8'h80, 8'h01, 8'h7F, 1'b0};
    tbl8[5] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    tbl1[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl1[1] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tbl1[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl1[3] = '{1'b1, 1'b1, 1'b0, 1'b0};

    // Reset held for two cycles with start asserted; request must not be taken.
    rst8 = 1'b1; start8 = 1'b1; a8 = 8'h05; b8 = 8'h03;
    rst1 = 1'b1; start1 = 1'b1; a1 = 1'b1;  b1 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_done", 32'(done8), 32'd0);
    check("reset_D", 32'(d8), 32'd0);
    check("reset_Bo", 32'(bo8), 32'd0);
    check("reset_busy_w1", 32'(busy1), 32'd0);
    rst8 = 1'b0; start8 = 1'b0;
    rst1 = 1'b0; start1 = 1'b0;
    @(negedge clk);
    check("reset_start_ignored", 32'(busy8), 32'd0);
    prev_d  = 8'h00;
    prev_bo = 1'b0;

    // Directed table, issued back-to-back at the earliest legal restart.
    for (int i = 0; i < 6; i++)
      op8($sformatf("vec%0d", i), tbl8[i].a, tbl8[i].b, tbl8[i].exp_d, tbl8[i].exp_bo, 0, 1'b0);

    // Start while busy (3rd busy cycle) and during the done cycle: both ignored.
    op8("start_while_busy", 8'h10, 8'h01, 8'h0F, 1'b0, 3, 1'b1);

    // Reset on the 4th busy cycle aborts without a done pulse.
    begin
      int  seen_done = 0;
      start8 = 1'b1; a8 = 8'h80; b8 = 8'h01;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_busy_before_rst", 32'(busy8), 32'd1);
      rst8 = 1'b1;
      @(negedge clk);
      rst8 = 1'b0;
      check("abort_busy", 32'(busy8), 32'd0);
      check("abort_D", 32'(d8), 32'd0);
      check("abort_Bo", 32'(bo8), 32'd0);
      for (int c = 0; c < 12; c++) begin
        if (done8) seen_done++;
        @(negedge clk);
      end
      check("abort_no_done", 32'(seen_done), 32'd0);
      prev_d  = 8'h00;
      prev_bo = 1'b0;
    end
    op8("after_abort", 8'h09, 8'h04, 8'h05, 1'b0, 0, 1'b0);

    // Randomized operations against plain unsigned arithmetic.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      int         diff;
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      if (i % 8 == 0) rb = ra;
      diff = int'(ra) - int'(rb);
      op8($sformatf("rand%0d_%02h_%02h", i, ra, rb), ra, rb,
          8'(diff + 256), (int'(ra) < int'(rb)), 0, 1'b0);
    end

    // WIDTH=1 exhaustive.
    for (int i = 0; i < 4; i++)
      op1($sformatf("w1_vec%0d", i), tbl1[i].a, tbl1[i].b, tbl1[i].exp_d, tbl1[i].exp_bo);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor: computes diff = A - B (mod 2^WIDTH) and a final borrow, one bit per clock, LSB first.
- Uses a start/busy/done handshake so a controller or testbench can issue operations.
- It is the inverse-direction companion of the combinational half-adder arithmetic and is built from half-subtractor cells plus a borrow register.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  minuend; captured on the accepted start edge
- B  input  WIDTH  subtrahend; captured on the accepted start edge
- busy  output  1  high while bits are being processed
- done  output  1  single-cycle completion pulse
- D  output  WIDTH  registered difference; valid from the done cycle until the next completion
- Bo  output  1  registered final borrow; 1 iff A < B (unsigned)

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; busy, done, D and Bo all become 0.
  - Internal shift registers, borrow register and bit counter cleared.
  - Reset has priority over every other input.
- States:
  - IDLE: busy=0, done=0. If start=1 at an edge: capture A and B into shift registers, clear the borrow register, set counter=0, go to SHIFT.
  - SHIFT: busy=1, done=0.
    - Each edge takes LSBs x, y and the borrow-in r.
    - d = x^y^r; bout = (~x&y) | (~(x^y)&r), formed from two half-subtractor cells ORed.
    - Shift d into the result register at the MSB end, shift the operands right, store bout, increment the counter.
    - On the edge that processes bit WIDTH-1: copy the result to D and bout to Bo, then go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle; next edge goes unconditionally to IDLE.
- Timing (start sampled at edge t0):
  - busy=1 in the W cycles following edges t0..t0+WIDTH-1.
  - D/Bo update at edge t0+WIDTH; done=1 in the cycle following that edge.
  - Earliest next accepted start is edge t0+WIDTH+2.
- Input handling:
  - start is ignored in SHIFT and DONE; no queuing.
  - A and B are don't-care except on the accepted start edge.
- Output holding: D and Bo hold their last result across IDLE and through the next operation until its completion edge. They are never partially updated.
- Widths:
  - Counter width is $clog2(WIDTH+1) so that WIDTH=1 is legal; WIDTH=1 completes after a single SHIFT cycle.
  - Arithmetic is unsigned, with wrap-around modulo 2^WIDTH; Bo is the only overflow indicator.
- Reset mid-operation: the operation is aborted, no done pulse is produced, outputs are 0, and the next start behaves normally.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2) and the default width constant.
- Sub-module half_subtractor:
  - Ports x, y -> d = x^y, b = ~x&y.
  - Instantiated twice to form the per-bit full subtract; the borrow OR is kept in the parent.

Test Plan (WIDTH=8 unless stated):
- Reset: hold rst=1 for 2 cycles -> busy=0, done=0, D=8'h00, Bo=0. Assert start=1 together with rst=1 -> the request is not accepted.
- Basic subtraction: A=8'h05, B=8'h03, start pulse -> busy high exactly 8 cycles, then done for 1 cycle with D=8'h02, Bo=0. Outputs hold after done.
- Borrow and wrap-around:
  - A=8'h03, B=8'h05 -> D=8'hFE, Bo=1.
  - A=8'h00, B=8'h01 -> D=8'hFF, Bo=1.
  - A=8'hFF, B=8'hFF -> D=8'h00, Bo=0.
- Start while busy: A=8'h10, B=8'h01 accepted; on the 3rd busy cycle drive start=1 with A=8'hAA, B=8'h55 -> ignored; the single done gives D=8'h0F, Bo=0. Start asserted during the DONE cycle is also ignored.
- Reset mid-operation: A=8'h80, B=8'h01; assert rst on the 4th busy cycle -> next cycle busy=0, D=8'h00, no done pulse. Then A=8'h09, B=8'h04 -> D=8'h05, Bo=0.
- WIDTH=1 exhaustive: all 4 (A,B) pairs -> busy for 1 cycle each. Required results (D,Bo): (0,0) -> (0,0); (0,1) -> (1,1); (1,0) -> (1,0); (1,1) -> (0,0).
